prescaler_multi: RTL

Multi-channel programmable prescaler, the parametrised successor to the single fixed-ratio prescaler. It provides CHANNELS independent dividers off one system clock. Each channel has a runtime-loadable divide ratio, an enable, a one-cycle `tick` strobe and a toggling `level` output. Downstream logic (PWM, timers, sequencers) uses these as clock enables, never as derived clocks.

---
 rtl/prescaler_pkg.sv | 21 ++
 rtl/prescaler_channel.sv | 101 ++++++++++
 rtl/prescaler_multi.sv | 67 ++++++
 3 files changed

// File: rtl/prescaler_pkg.sv
// -----------------------------------------------------------------------------
// prescaler_pkg
//
// Shared constants and helpers for the multi-channel prescaler.
//   PRESCALER_DEFAULT_DIV : divisor loaded into every channel on reset
//                           (tick period DEFAULT+1 cycles).
//   sel_width()           : width of the channel-select field, which is
//                           clog2(channels) with a floor of one bit so that a
//                           single-channel build still has a legal port.
// -----------------------------------------------------------------------------
package prescaler_pkg;

    localparam int PRESCALER_DEFAULT_DIV = 9;

    function automatic int sel_width(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : prescaler_pkg

// File: rtl/prescaler_channel.sv
// -----------------------------------------------------------------------------
// prescaler_channel
//
// One divider channel. The counter runs 0..div_act and wraps, giving a tick
// every div_act+1 cycles and a level that toggles on each tick. New divisors
// written while the channel runs are parked in a shadow register and adopted
// at the next wrap, so a period is never cut short or stretched mid-count.
//
// Ports:
//   clk      in  1      system clock, rising edge
//   rst      in  1      synchronous active-high reset
//   en       in  1      run enable for this channel
//   sync_clr in  1      phase-align strobe (clears counter and outputs)
//   load     in  1      divisor write strobe already decoded for this channel
//   value    in  WIDTH  divisor to write
//   tick     out 1      registered one-cycle strobe
//   level    out 1      registered square wave, toggles on every tick
// -----------------------------------------------------------------------------
module prescaler_channel #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             tick,
    output logic             level
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             pend_v;
    logic             wrap;

    // cnt is only ever reset or advanced up to div_act, so equality is the
    // sole wrap condition and the increment cannot overflow.
    assign wrap = (cnt == div_act);

    // Control state: counter, active divisor, pending flag and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= WIDTH'(DEFAULT_DIV);
            pend_v  <= 1'b0;
            tick    <= 1'b0;
            level   <= 1'b0;
        end else if (sync_clr) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
            // A write coinciding with the clear goes straight to the active
            // divisor and supersedes anything still pending.
            if (load) begin
                div_act <= value;
                pend_v  <= 1'b0;
            end else if (pend_v) begin
                div_act <= div_pend;
                pend_v  <= 1'b0;
            end
        end else if (en) begin
            if (wrap) begin
                cnt   <= '0;
                tick  <= 1'b1;
                level <= ~level;
                if (pend_v) begin
                    div_act <= div_pend;
                end
            end else begin
                cnt  <= cnt + WIDTH'(1);
                tick <= 1'b0;
            end
            // A write landing on the wrap cycle is queued for the following
            // wrap; the value adopted now is the one already pending.
            if (load) begin
                pend_v <= 1'b1;
            end else if (wrap) begin
                pend_v <= 1'b0;
            end
        end else begin
            cnt  <= '0;
            tick <= 1'b0;
            // Stopped channel: no period in progress, so apply immediately.
            if (load) begin
                div_act <= value;
                pend_v  <= 1'b0;
            end
        end
    end

    // Shadow divisor is pure data qualified by pend_v, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load && en && !sync_clr) begin
            div_pend <= value;
        end
    end

endmodule : prescaler_channel

// File: rtl/prescaler_multi.sv
// -----------------------------------------------------------------------------
// prescaler_multi
//
// CHANNELS independent programmable dividers off one clock. Each channel
// produces a one-cycle tick every D+1 cycles and a level output with period
// 2*(D+1). Outputs are intended as clock enables for downstream logic.
//
// Ports:
//   clk       in  1         system clock, rising edge
//   rst       in  1         synchronous active-high reset
//   en        in  CHANNELS  per-channel run enable
//   sync_clr  in  1         phase-align all channels
//   div_load  in  1         divisor write strobe
//   div_sel   in  SEL_W     channel index for the write (>= CHANNELS ignored)
//   div_value in  WIDTH     new divisor D
//   tick      out CHANNELS  registered one-cycle strobes
//   level     out CHANNELS  registered square waves
// -----------------------------------------------------------------------------
module prescaler_multi
    import prescaler_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = PRESCALER_DEFAULT_DIV,
    parameter int SEL_W       = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync_clr,
    input  logic                div_load,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_value,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("prescaler_multi: CHANNELS must be 1..16");
    end

    if (WIDTH < 32 && DEFAULT_DIV >= (1 << WIDTH)) begin : g_bad_default
        $error("prescaler_multi: DEFAULT_DIV does not fit in WIDTH");
    end

    logic [CHANNELS-1:0] load_ch;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Indices at or beyond CHANNELS never match, so such writes vanish.
        assign load_ch[i] = div_load && (div_sel == SEL_W'(i));

        prescaler_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .sync_clr (sync_clr),
            .load     (load_ch[i]),
            .value    (div_value),
            .tick     (tick[i]),
            .level    (level[i])
        );
    end

endmodule : prescaler_multi
